// File: rtl/pcm_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_framer_pkg
//  Description : Shared defaults and FSM state encoding for the PCM framer.
//  Revision    : 1.0  initial release
// ============================================================================
package pcm_framer_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAME_LEN_DEF = 64;
  localparam int HOP_DEF       = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_EMIT     = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pcm_framer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_framer_ram
//  Description : Simple dual-port sample store, one write port and one
//                synchronous read port whose output holds while rd_en is low.
//  Revision    : 1.0  initial release
// ============================================================================
module pcm_framer_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 96,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Write port and registered read; read data is held when no read is issued
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  assign rd_data = rd_q;

endmodule
`default_nettype wire

// File: rtl/pcm_framer.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_framer
//  Description : Collects decimated PCM samples into a ring and streams
//                overlapping frames of FRAME_LEN samples, advancing HOP samples
//                per frame. Samples arriving with the ring full are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module pcm_framer
  import pcm_framer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int HOP       = HOP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pcm_in,
  input  logic              pcm_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              overrun,
  output logic              overrun_sticky
);

  localparam int DEPTH   = FRAME_LEN + HOP;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int AVAIL_W = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(FRAME_LEN);

  localparam logic [AVAIL_W-1:0] DEPTH_A  = AVAIL_W'(DEPTH);
  localparam logic [AVAIL_W-1:0] FL_A     = AVAIL_W'(FRAME_LEN);
  localparam logic [AVAIL_W-1:0] HOP_A    = AVAIL_W'(HOP);
  localparam logic [PTR_W:0]     HOP_P    = (PTR_W+1)'(HOP);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e               state_q,   state_d;
  logic [PTR_W-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]     base_q,    base_d;
  logic [AVAIL_W-1:0]   avail_q,   avail_d;
  logic [IDX_W-1:0]     rd_idx_q,  rd_idx_d;
  logic                 overrun_q, overrun_d;
  logic                 sticky_q,  sticky_d;

  logic                 wr_accept, drop, beat_acc, last_acc;
  logic                 rd_en;
  logic [PTR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]    rd_data;

  // Ring addresses wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] a,
                                               input logic [PTR_W:0]   b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + b;
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Next-state, ring bookkeeping and RAM read control
  always_comb begin
    wr_accept = pcm_valid && (avail_q != DEPTH_A);
    drop      = pcm_valid && (avail_q == DEPTH_A);
    beat_acc  = (state_q == ST_EMIT) && m_ready;
    last_acc  = beat_acc && (rd_idx_q == LAST_IDX);

    state_d   = state_q;
    wr_ptr_d  = wr_accept ? ptr_add(wr_ptr_q, (PTR_W+1)'(1)) : wr_ptr_q;
    base_d    = base_q;
    rd_idx_d  = rd_idx_q;
    rd_en     = 1'b0;
    rd_addr   = base_q;
    overrun_d = drop;
    sticky_d  = sticky_q | drop;

    avail_d = avail_q;
    if (wr_accept) avail_d = avail_d + AVAIL_W'(1);
    if (last_acc)  avail_d = avail_d - HOP_A;

    case (state_q)
      ST_IDLE: begin
        if (avail_q >= FL_A) state_d = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        rd_en    = 1'b1;
        rd_addr  = base_q;
        rd_idx_d = '0;
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        if (last_acc) begin
          rd_idx_d = '0;
          base_d   = ptr_add(base_q, HOP_P);
          state_d  = (avail_d >= FL_A) ? ST_PREFETCH : ST_IDLE;
        end else if (beat_acc) begin
          rd_en    = 1'b1;
          rd_addr  = ptr_add(base_q, (PTR_W+1)'(rd_idx_q) + (PTR_W+1)'(1));
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and pointer registers; reset abandons any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      base_q    <= '0;
      avail_q   <= '0;
      rd_idx_q  <= '0;
      overrun_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      base_q    <= base_d;
      avail_q   <= avail_d;
      rd_idx_q  <= rd_idx_d;
      overrun_q <= overrun_d;
      sticky_q  <= sticky_d;
    end
  end

  pcm_framer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept && !rst),
    .wr_addr (wr_ptr_q),
    .wr_data (pcm_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign m_valid        = (state_q == ST_EMIT);
  assign m_last         = m_valid && (rd_idx_q == LAST_IDX);
  assign m_data         = m_valid ? rd_data : '0;
  assign overrun        = overrun_q;
  assign overrun_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcm_framer
//  Description : Self-checking bench for pcm_framer (FRAME_LEN=8, HOP=4).
//                The reference is a queue of stored samples from the frame
//                base onward; frames are its first FRAME_LEN entries.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcm_framer;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 8;
  localparam int HOP       = 4;
  localparam int DEPTH     = FRAME_LEN + HOP;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] pcm_in = '0;
  logic              pcm_valid = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              overrun;
  logic              overrun_sticky;

  pcm_framer #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .HOP       (HOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pcm_in         (pcm_in),
    .pcm_valid      (pcm_valid),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .overrun        (overrun),
    .overrun_sticky (overrun_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model [$];
  int   beat, frames, cyc, first_valid_cyc, first_last_cyc, ovr_count;
  logic exp_ovr, exp_sticky, gap_due, hold_due, hold_last;
  logic [DATA_W-1:0] hold_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check outputs, advance model
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    logic acc;
    pcm_valid = v; pcm_in = d; m_ready = rdy;
    #1;
    check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    check("sticky", {31'd0, overrun_sticky}, {31'd0, exp_sticky});
    if (overrun === 1'b1) ovr_count++;
    if (gap_due) check("frame_gap", {31'd0, m_valid}, 32'd0);
    if (hold_due) begin
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_data", {16'd0, m_data}, {16'd0, hold_data});
      check("hold_last", {31'd0, m_last}, {31'd0, hold_last});
    end
    if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    acc = (m_valid === 1'b1) && rdy;
    if (m_valid === 1'b1 && model.size() < FRAME_LEN)
      check("early_valid", {31'd0, m_valid}, 32'd0);
    else if (acc) begin
      check("beat_data", {16'd0, m_data}, {16'd0, model[beat]});
      check("beat_last", {31'd0, m_last}, {31'd0, (beat == FRAME_LEN - 1)});
    end
    hold_due  = (m_valid === 1'b1) && !rdy;
    hold_data = m_data;
    hold_last = m_last;
    gap_due   = acc && (beat == FRAME_LEN - 1);
    exp_ovr   = v && (model.size() == DEPTH);
    exp_sticky = exp_sticky | exp_ovr;
    if (v && !exp_ovr) model.push_back(d);
    if (acc && model.size() >= FRAME_LEN) begin
      if (beat == FRAME_LEN - 1) begin
        repeat (HOP) void'(model.pop_front());
        beat = 0;
        frames++;
        if (frames == 1) first_last_cyc = cyc;
      end else beat++;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Reset for one clock with a stray sample offered, then check reset outputs
  task automatic do_reset();
    rst = 1'b1; pcm_valid = 1'b1; pcm_in = 16'($urandom); m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; pcm_valid = 1'b0;
    model.delete();
    beat = 0; frames = 0; cyc = 0; first_valid_cyc = -1; first_last_cyc = -1;
    ovr_count = 0; exp_ovr = 1'b0; exp_sticky = 1'b0; gap_due = 1'b0; hold_due = 1'b0;
    #1;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_data", {16'd0, m_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_sticky", {31'd0, overrun_sticky}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Continuous input 1..12, then 13..16 once the first frame is out
    do_reset();
    for (int i = 1; i <= 12; i++) cycle(1'b1, 16'(i), 1'b1);
    for (int k = 0; k < 40 && frames < 1; k++) cycle(1'b0, 16'd0, 1'b1);
    for (int i = 13; i <= 16; i++) cycle(1'b1, 16'(i), 1'b1);
    repeat (60) cycle(1'b0, 16'd0, 1'b1);
    check("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd10);
    check("t1_first_last_cyc", 32'(first_last_cyc), 32'd17);
    check("t1_frames", 32'(frames), 32'd3);

    // Downstream toggling ready every cycle
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'(i % 2));
    for (int k = 0; k < 40; k++) cycle(1'b0, 16'd0, 1'(k % 2));
    check("t2_frames", 32'(frames), 32'd1);

    // Write coincident with final beat at avail 11
    do_reset();
    for (int i = 1; i <= 11; i++) cycle(1'b1, 16'(i), 1'b0);
    for (int k = 0; k < 40 && frames < 1; k++)
      cycle((m_valid === 1'b1) && (m_last === 1'b1), 16'd12, 1'b1);
    check("t4_gap", {31'd0, m_valid}, 32'd0);
    cycle(1'b0, 16'd0, 1'b1);
    check("t4_restart", {31'd0, m_valid}, 32'd1);
    repeat (30) cycle(1'b0, 16'd0, 1'b1);
    check("t4_frames", 32'(frames), 32'd2);

    // Stalled downstream, 13 samples: one dropped
    do_reset();
    for (int i = 1; i <= 13; i++) cycle(1'b1, 16'(i), 1'b0);
    repeat (3) cycle(1'b0, 16'd0, 1'b0);
    check("t3_ovr_pulses", 32'(ovr_count), 32'd1);
    check("t3_sticky", {31'd0, overrun_sticky}, 32'd1);
    repeat (40) cycle(1'b0, 16'd0, 1'b1);
    check("t3_frames", 32'(frames), 32'd2);

    // Reset at beat 3 of a frame, with sticky set beforehand
    for (int i = 101; i <= 104; i++) cycle(1'b1, 16'(i), 1'b1);
    for (int k = 0; k < 20 && !(beat == 2 && m_valid === 1'b1); k++)
      cycle(1'b0, 16'd0, 1'b1);
    check("t5_at_beat3", {31'd0, m_valid}, 32'd1);
    do_reset();
    for (int i = 201; i <= 207; i++) cycle(1'b1, 16'(i), 1'b1);
    repeat (8) cycle(1'b0, 16'd0, 1'b1);
    check("t5_no_early_frame", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    cycle(1'b1, 16'd208, 1'b1);
    repeat (20) cycle(1'b0, 16'd0, 1'b1);
    check("t5_frames", 32'(frames), 32'd1);

    // Random traffic with occasional resets
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcm_framer.md
PCM_FRAMER -- requirements
Module: pcm_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, PCM sample width (signed two's complement).
REQ-002 SHALL have parameter FRAME_LEN, default 64, samples per output frame; power of two, 4..256.
REQ-003 SHALL have parameter HOP, default 32, new samples between successive frame starts; power of two, 1..FRAME_LEN.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port pcm_in  input  DATA_W  decimated PCM sample from the CIC/HPF stage.
REQ-007 SHALL have port pcm_valid  input  1  one-cycle qualifier for pcm_in; no backpressure upstream.
REQ-008 SHALL have port m_data  output  DATA_W  frame sample, oldest first.
REQ-009 SHALL have port m_valid  output  1  m_data/m_last valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts beat when m_valid && m_ready.
REQ-011 SHALL have port m_last  output  1  high on final (FRAME_LEN-th) beat of a frame.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when an input sample is dropped.
REQ-013 SHALL have port overrun_sticky  output  1  set on any overrun, cleared only by rst.

Function
REQ-014 SHALL store samples in a ring of DEPTH = FRAME_LEN + HOP entries; write pointer wraps from DEPTH-1 to 0.
REQ-015 SHALL keep avail = stored samples from frame base onward, range 0..DEPTH.
REQ-016 SHALL on pcm_valid with avail < DEPTH write pcm_in at wr_ptr, advance wr_ptr, increment avail.
REQ-017 SHALL on pcm_valid with avail == DEPTH (registered value, including on a final-beat cycle) drop the sample, pulse overrun next cycle, set overrun_sticky.
REQ-018 SHALL run FSM IDLE -> PREFETCH -> EMIT -> IDLE/PREFETCH.
REQ-019 SHALL in IDLE move to PREFETCH when avail >= FRAME_LEN.
REQ-020 SHALL in PREFETCH issue synchronous RAM read at base, enter EMIT; m_valid rises 2 cycles after avail first reaches FRAME_LEN.
REQ-021 SHALL in EMIT present entries base, base+1, ... base+FRAME_LEN-1 (mod DEPTH), one per accepted beat, back-to-back at 1 beat/cycle while m_ready high.
REQ-022 SHALL hold m_data, m_last stable and m_valid high while m_valid && !m_ready.
REQ-023 SHALL on final beat accepted advance base by HOP (mod DEPTH) and set avail = avail - HOP (+1 if same-cycle write accepted).
REQ-024 SHALL after final beat go to PREFETCH if the updated avail >= FRAME_LEN, else IDLE; m_valid low for at least one cycle between frames.
REQ-025 SHALL never overwrite an entry of the frame being emitted (guaranteed by REQ-014/017).
REQ-026 SHALL emit first frame only after FRAME_LEN samples since reset; HOP == FRAME_LEN gives non-overlapping frames.

Reset
REQ-027 SHALL on rst clear wr_ptr, base, avail, read index to 0 and enter IDLE.
REQ-028 SHALL on rst drive m_valid=0, m_last=0, m_data=0, overrun=0, overrun_sticky=0 the following cycle.
REQ-029 SHALL on rst mid-frame abandon the frame without asserting m_last; RAM contents need not be cleared.
REQ-030 SHALL ignore pcm_valid in the cycle rst is high.

Structure
REQ-031 SHALL place DATA_W default, FRAME_LEN/HOP defaults and the FSM state enum in shared package pcm_framer_pkg.
REQ-032 SHALL instantiate one sub-module pcm_framer_ram: simple dual-port, DEPTH x DATA_W, one write port, one synchronous-read port.
REQ-033 SHALL size pointers to ceil(log2(DEPTH)) bits and avail to ceil(log2(DEPTH+1)) bits.

Verification (FRAME_LEN=8, HOP=4, DATA_W=16)
REQ-034 SHALL verify: pcm_valid every cycle, pcm_in 1..8, m_ready=1 -> m_valid 2 cycles after 8th write, beats 1..8 back-to-back, m_last on 8.
REQ-035 SHALL verify: continue to 12 samples -> second frame 5..12, then 9..16 after 16 (overlap 4, pointer wrap across DEPTH=12).
REQ-036 SHALL verify: m_ready toggled 1/0 each cycle during frame -> same 8 values in order, data held on stalls, no duplicates.
REQ-037 SHALL verify: m_ready=0 with 13 samples written -> 13th dropped, overrun one pulse, sticky stays 1; frame after release is 1..8, next 5..12.
REQ-038 SHALL verify: write coincident with final beat at avail=11 -> accepted, avail becomes 8, next frame starts immediately.
REQ-039 SHALL verify: rst asserted at beat 3 -> m_valid low next cycle, overrun_sticky 0, next frame only after 8 fresh samples.
